mc_datapath: RTL and testbench

// Multicycle successor of the single-cycle MIPS datapath: one shared memory port, internal

---
 rtl/mc_datapath.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: one shared req/ready memory port, internal register file and a
// Fetch/Decode/Exec/Mem/Writeback control FSM with a sticky error state.
module mc_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [31:0]      pc,
   output logic             retire,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             illegal
);
   localparam int unsigned RA_W = $clog2(NREGS);
   // Bit i set when register index i exists.
   localparam logic [31:0] RegValid = (NREGS >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << NREGS) - 32'd1);

   localparam logic [5:0] OpR = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
   localparam logic [5:0] OpAddi = 6'h08, OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;
   localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   typedef enum logic [2:0] {
      StFetch, StDecode, StExec, StMem, StRwb, StIwb, StLwb, StError
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0]      alu_q, alu_d, mdr_q, mdr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rf_q [NREGS];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] sext_imm, ea, alu_r, rf_a, rf_b;
   logic        op_ok, idx_bad, use_rs, use_rt, use_rd, taken;
   logic        req_c, we_c, retire_c, rf_we;
   logic [31:0] addr_c, wdata_c, rf_wdata;
   logic [4:0]  rf_waddr;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm      = ir_q[15:0];
   assign sext_imm = {{16{imm[15]}}, imm};
   assign ea       = a_q + sext_imm;
   // r0 is never written, so it always reads back as zero.
   assign rf_a     = rf_q[rs[RA_W-1:0]];
   assign rf_b     = rf_q[rt[RA_W-1:0]];
   assign taken    = (a_q == b_q) ^ (op == OpBne);

   always_comb begin
      op_ok  = 1'b1;
      use_rs = 1'b1;
      use_rt = 1'b1;
      use_rd = 1'b0;
      case (op)
         OpR:                              begin
            use_rd = 1'b1;
            op_ok  = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
         end
         OpLw, OpSw, OpBeq, OpBne, OpAddi: op_ok = 1'b1;
         OpLui:                            use_rs = 1'b0;
         OpJ:                              begin
            use_rs = 1'b0;
            use_rt = 1'b0;
         end
         default:                          op_ok = 1'b0;
      endcase
      idx_bad = (use_rs & ~RegValid[rs]) | (use_rt & ~RegValid[rt]) | (use_rd & ~RegValid[rd]);
   end

   always_comb begin
      case (funct)
         FnSub:   alu_r = a_q - b_q;
         FnAnd:   alu_r = a_q & b_q;
         FnOr:    alu_r = a_q | b_q;
         FnSlt:   alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
         default: alu_r = a_q + b_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      req_c    = 1'b0;
      we_c     = 1'b0;
      addr_c   = '0;
      wdata_c  = '0;
      retire_c = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      case (state_q)
         StFetch: begin
            req_c  = 1'b1;
            addr_c = pc_q;
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 32'd4;
               state_d = StDecode;
            end
         end
         StDecode: begin
            a_d   = rf_a;
            b_d   = rf_b;
            alu_d = pc_q + {sext_imm[29:0], 2'b00};
            if (!op_ok || idx_bad) begin
               state_d = StError;
            end else if (op == OpJ) begin
               pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
               retire_c = 1'b1;
               state_d  = StFetch;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            case (op)
               OpR: begin
                  alu_d   = alu_r;
                  state_d = StRwb;
               end
               OpLw, OpSw: begin
                  alu_d   = ea;
                  state_d = (ea[1:0] != 2'b00) ? StError : StMem;
               end
               OpBeq, OpBne: begin
                  if (taken) pc_d = alu_q;
                  retire_c = 1'b1;
                  state_d  = StFetch;
               end
               OpAddi: begin
                  alu_d   = ea;
                  state_d = StIwb;
               end
               OpLui: begin
                  alu_d   = {imm, 16'h0000};
                  state_d = StIwb;
               end
               default: state_d = StError;
            endcase
         end
         StMem: begin
            req_c   = 1'b1;
            we_c    = (op == OpSw);
            addr_c  = alu_q;
            wdata_c = we_c ? b_q : 32'h0;
            if (mem_ready) begin
               if (we_c) begin
                  retire_c = 1'b1;
                  state_d  = StFetch;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = StLwb;
               end
            end
         end
         StRwb, StIwb, StLwb: begin
            rf_we    = 1'b1;
            rf_waddr = (state_q == StRwb) ? rd : rt;
            rf_wdata = (state_q == StLwb) ? mdr_q : alu_q;
            retire_c = 1'b1;
            state_d  = StFetch;
         end
         default: state_d = StError;
      endcase
      cnt_d = cnt_q + CNT_W'(retire_c);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
         if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr[RA_W-1:0]] <= rf_wdata;
      end
   end

   // Held in FETCH during reset; gate so the port is quiet until reset releases.
   assign mem_req    = req_c & reset;
   assign mem_we     = we_c & reset;
   assign mem_addr   = reset ? addr_c : 32'h0;
   assign mem_wdata  = reset ? wdata_c : 32'h0;
   assign pc         = pc_q;
   assign retire     = retire_c;
   assign retire_cnt = cnt_q;
   assign illegal    = (state_q == StError);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: small programs run from a wait-state-configurable memory model,
// results checked via stored words, cycle-exact retire counts and port state.
module tb_mc_datapath;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req, mem_we, mem_ready = 1'b0, retire, illegal;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, pc;
   logic [31:0] retire_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];
   int          wait_states = 0;
   int          wcnt = 0;
   int          hold_cycles = 0;
   int          hold_bad = 0;
   logic        prev_req = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;

   localparam logic [5:0] OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05, OpAddi = 6'h08;
   localparam logic [5:0] OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;

   mc_datapath dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .retire    (retire),
      .retire_cnt(retire_cnt),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Memory model: ready is decided at the falling edge for the next rising edge.
   always @(negedge clk) begin
      if (mem_req && prev_req && !prev_ready) begin
         hold_cycles++;
         if (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata) hold_bad++;
      end
      prev_req   = mem_req;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (mem_req && wcnt >= wait_states) begin
         mem_ready = 1'b1;
         mem_rdata = mem[mem_addr[9:2]];
         if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
         wcnt = 0;
      end else if (mem_req) begin
         mem_ready = 1'b0;
         mem_rdata = '0;
         wcnt++;
      end else begin
         mem_ready = 1'b0;
         wcnt = 0;
      end
      prev_ready = mem_ready;
   end

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                         input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic begin_program(input int ws);
      reset = 1'b0;
      wait_states = ws;
      step(1);
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic release_reset;
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset;
      begin_program(0);
      step(1);
      checks++;
      if ({mem_req, mem_we, retire, illegal} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got req/we/ret/ill=%b want 0000",
                  {mem_req, mem_we, retire, illegal});
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
      end
      checks++;
      if (pc !== 32'h0 || retire_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc_cnt got pc=%h cnt=%0d want 0/0", pc, retire_cnt);
      end
   endtask

   task automatic test_alu_branch;
      logic [31:0] exp_w [8];
      exp_w = '{32'd2, 32'd1, 32'd0, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'h1234_0000, 32'd0};
      begin_program(0);
      mem[0]  = enc_i(OpAddi, 0, 1, 5);
      mem[1]  = enc_i(OpAddi, 0, 2, -3);
      mem[2]  = enc_r(1, 2, 3, 6'h20);
      mem[3]  = enc_r(2, 1, 4, 6'h2A);
      mem[4]  = enc_r(1, 2, 7, 6'h2A);
      mem[5]  = enc_r(1, 2, 8, 6'h22);
      mem[6]  = enc_r(1, 2, 9, 6'h24);
      mem[7]  = enc_r(1, 2, 10, 6'h25);
      mem[8]  = enc_i(OpLui, 0, 6, 16'h1234);
      mem[9]  = enc_i(OpAddi, 0, 0, 7);
      mem[10] = enc_i(OpSw, 0, 3, 32'h200);
      mem[11] = enc_i(OpSw, 0, 4, 32'h204);
      mem[12] = enc_i(OpSw, 0, 7, 32'h208);
      mem[13] = enc_i(OpSw, 0, 8, 32'h20C);
      mem[14] = enc_i(OpSw, 0, 9, 32'h210);
      mem[15] = enc_i(OpSw, 0, 10, 32'h214);
      mem[16] = enc_i(OpSw, 0, 6, 32'h218);
      mem[17] = enc_i(OpSw, 0, 0, 32'h21C);
      mem[18] = enc_i(OpBne, 1, 1, -1);
      mem[19] = {OpJ, 26'h40};
      mem[64] = enc_i(OpBeq, 1, 1, -1);
      mem[135] = 32'hDEAD_BEEF;
      release_reset();
      step(11);
      checks++;
      if (retire !== 1'b1 || retire_cnt !== 32'd2) begin
         errors++;
         $display("FAIL alu_cycle11 got retire=%b cnt=%0d want 1/2", retire, retire_cnt);
      end
      step(1);
      checks++;
      if (retire_cnt !== 32'd3 || pc !== 32'd12) begin
         errors++;
         $display("FAIL alu_cycle12 got cnt=%0d pc=%h want 3/0000000c", retire_cnt, pc);
      end
      step(65);
      checks++;
      if (retire_cnt !== 32'd20 || pc !== 32'h100) begin
         errors++;
         $display("FAIL jump_cycle77 got cnt=%0d pc=%h want 20/00000100", retire_cnt, pc);
      end
      step(1);
      checks++;
      if (pc !== 32'h104) begin
         errors++;
         $display("FAIL beq_fetch got pc=%h want 00000104", pc);
      end
      step(2);
      checks++;
      if (pc !== 32'h100 || retire_cnt !== 32'd21 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL beq_selfloop got pc=%h cnt=%0d ill=%b want 00000100/21/0",
                  pc, retire_cnt, illegal);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (mem[128+i] !== exp_w[i]) begin
            errors++;
            $display("FAIL alu_store%0d got %h want %h", i, mem[128+i], exp_w[i]);
         end
      end
   endtask

   task automatic test_mem_wait;
      begin_program(3);
      mem[0] = enc_i(OpAddi, 0, 1, 5);
      mem[1] = enc_i(OpSw, 0, 1, 32'h200);
      mem[2] = enc_i(OpLw, 0, 5, 32'h200);
      mem[3] = enc_i(OpSw, 0, 5, 32'h204);
      mem[4] = enc_i(OpBeq, 0, 0, -1);
      hold_cycles = 0;
      hold_bad = 0;
      release_reset();
      step(14);
      checks++;
      if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h200 || mem_wdata !== 32'd5) begin
         errors++;
         $display("FAIL sw_wait_bus got req/we=%b addr=%h wdata=%h want 11/00000200/5",
                  {mem_req, mem_we}, mem_addr, mem_wdata);
      end
      step(13);
      checks++;
      if (retire !== 1'b1 || retire_cnt !== 32'd2) begin
         errors++;
         $display("FAIL lw_cycle27 got retire=%b cnt=%0d want 1/2", retire, retire_cnt);
      end
      step(1);
      checks++;
      if (retire_cnt !== 32'd3) begin
         errors++;
         $display("FAIL lw_cycle28 got cnt=%0d want 3", retire_cnt);
      end
      step(30);
      checks++;
      if (mem[128] !== 32'd5 || mem[129] !== 32'd5) begin
         errors++;
         $display("FAIL lw_result got %h/%h want 5/5", mem[128], mem[129]);
      end
      checks++;
      if (hold_bad !== 0 || hold_cycles < 12) begin
         errors++;
         $display("FAIL hold_stable got bad=%0d cycles=%0d want 0/>=12", hold_bad, hold_cycles);
      end
   endtask

   task automatic test_illegal;
      int reqs;
      begin_program(0);
      mem[0] = enc_i(OpAddi, 0, 1, 1);
      mem[1] = {6'h3F, 26'h0};
      release_reset();
      step(10);
      checks++;
      if (illegal !== 1'b1 || pc !== 32'd8 || retire_cnt !== 32'd1) begin
         errors++;
         $display("FAIL bad_opcode got ill=%b pc=%h cnt=%0d want 1/00000008/1",
                  illegal, pc, retire_cnt);
      end
      reqs = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req) reqs++;
      end
      checks++;
      if (reqs != 0) begin
         errors++;
         $display("FAIL error_quiet got %0d request cycles want 0", reqs);
      end
      begin_program(0);
      mem[0] = enc_r(1, 2, 3, 6'h3F);
      release_reset();
      step(6);
      checks++;
      if (illegal !== 1'b1 || pc !== 32'd4 || retire_cnt !== 32'd0) begin
         errors++;
         $display("FAIL bad_funct got ill=%b pc=%h cnt=%0d want 1/00000004/0",
                  illegal, pc, retire_cnt);
      end
      begin_program(0);
      mem[0] = enc_i(OpLw, 0, 1, 2);
      release_reset();
      step(6);
      checks++;
      if (illegal !== 1'b1 || retire_cnt !== 32'd0) begin
         errors++;
         $display("FAIL misaligned got ill=%b cnt=%0d want 1/0", illegal, retire_cnt);
      end
   endtask

   task automatic test_reset_mid;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (illegal !== 1'b0 || pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_clears_error got ill=%b pc=%h want 0/0", illegal, pc);
      end
      begin_program(3);
      mem[0] = enc_i(OpLw, 0, 1, 32'h200);
      release_reset();
      step(7);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL lw_pending got req=%b addr=%h want 1/00000200", mem_req, mem_addr);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || pc !== 32'h0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_lw got req=%b addr=%h pc=%h ill=%b want 0/0/0/0",
                  mem_req, mem_addr, pc, illegal);
      end
      release_reset();
      step(4);
      checks++;
      if (pc !== 32'd4 || retire_cnt !== 32'd0) begin
         errors++;
         $display("FAIL refetch got pc=%h cnt=%0d want 00000004/0", pc, retire_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_alu_branch();
      test_mem_wait();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
